// File: rtl/ring_cadence_gen_pkg.sv
// ============================================================================
// Module   : ring_pkg
// Purpose  : Shared definitions for the ring cadence generator: the FSM state
//            encoding, the default cadence constants and the timer width
//            helper used to size the shared cadence down-counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_pkg;

    // Controller states (encoding is fixed for compatibility with ringer_module tooling)
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RING_ON    = 2'd1,
        RING_OFF   = 2'd2,
        WAIT_CLEAR = 2'd3
    } ring_state_e;

    // Default cadence: 8 cycles on, 16 cycles off, 4 bursts
    localparam int C_DEF_ON_CYCLES  = 8;
    localparam int C_DEF_OFF_CYCLES = 16;
    localparam int C_DEF_MAX_RINGS  = 4;
    localparam int C_DEF_CNT_W      = 8;

    // Timer must hold ON_CYCLES-1 and OFF_CYCLES-1; never narrower than 1 bit.
    function automatic int timer_width(input int on_cycles, input int off_cycles);
        int m;
        int w;
        m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : ring_pkg

`default_nettype wire

// File: rtl/ring_cadence_gen_timer.sv
// ============================================================================
// Module   : cadence_timer
// Purpose  : Loadable down-counter shared by the ON and OFF ring phases.
//            A load takes priority over counting; counting stops at zero.
// Ports    : clk, rst_n  - clock, synchronous active-low reset
//            load        - load load_val this cycle
//            load_val    - reload value
//            en          - decrement enable
//            zero        - counter currently equals zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cadence_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : cadence_timer

`default_nettype wire

// File: rtl/ring_cadence_gen.sv
// ============================================================================
// Module   : ring_cadence_gen
// Purpose  : Turns a level "incoming call" request into a cadenced ring
//            request for ringer_module: ON_CYCLES high, OFF_CYCLES low, for
//            MAX_RINGS bursts. Aborts on answer or caller hang-up; pulses
//            missed when the bursts run out and then waits for call_in to drop.
// Ports    : clk, rst_n   - clock, synchronous active-low reset
//            call_in      - high while a call is incoming
//            answer       - user answered
//            ring         - cadenced ring request (registered)
//            ringing      - high in RING_ON / RING_OFF (registered)
//            ring_num     - current burst number 1..MAX_RINGS, else 0
//            missed       - one-cycle missed-call pulse
//            clr_missed   - (RING_MISSED_COUNT_EN) clear missed counter
//            missed_count - (RING_MISSED_COUNT_EN) saturating missed count
// Config   : define RING_MISSED_COUNT_EN to add the missed-call counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_cadence_gen
    import ring_pkg::*;
#(
    parameter int ON_CYCLES  = C_DEF_ON_CYCLES,
    parameter int OFF_CYCLES = C_DEF_OFF_CYCLES,
    parameter int MAX_RINGS  = C_DEF_MAX_RINGS,
    parameter int CNT_W      = C_DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           call_in,
    input  logic                           answer,
    output logic                           ring,
    output logic                           ringing,
    output logic [$clog2(MAX_RINGS+1)-1:0] ring_num,
    output logic                           missed
`ifdef RING_MISSED_COUNT_EN
    ,
    input  logic                           clr_missed,
    output logic [CNT_W-1:0]               missed_count
`endif
);

    localparam int C_TMR_W = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam int C_NUM_W = $clog2(MAX_RINGS + 1);

    localparam logic [1:0] C_ST_IDLE       = IDLE;
    localparam logic [1:0] C_ST_RING_ON    = RING_ON;
    localparam logic [1:0] C_ST_RING_OFF   = RING_OFF;
    localparam logic [1:0] C_ST_WAIT_CLEAR = WAIT_CLEAR;

    localparam logic [C_TMR_W-1:0] C_ON_LOAD  = C_TMR_W'(ON_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_OFF_LOAD = C_TMR_W'(OFF_CYCLES - 1);
    localparam logic [C_NUM_W-1:0] C_MAX_NUM  = C_NUM_W'(MAX_RINGS);
    localparam logic [C_NUM_W-1:0] C_NUM_ONE  = C_NUM_W'(1);

    // Elaboration-time parameter sanity checks
    generate
        if ((ON_CYCLES < 1) || (OFF_CYCLES < 1) || (MAX_RINGS < 1) || (CNT_W < 1)) begin : g_param_check
            $error("ring_cadence_gen: ON_CYCLES, OFF_CYCLES, MAX_RINGS and CNT_W must all be >= 1");
        end
    endgenerate

    logic [1:0]         r_state;
    logic               r_ring;
    logic               r_ringing;
    logic [C_NUM_W-1:0] r_ring_num;
    logic               r_missed;

    logic [1:0]         w_state_nxt;
    logic [C_NUM_W-1:0] w_num_nxt;
    logic               w_missed_nxt;
    logic               w_tmr_load;
    logic [C_TMR_W-1:0] w_tmr_val;
    logic               w_tmr_en;
    logic               w_tmr_zero;
    logic               w_abort;

    // Hang-up or answer ends an active call; checked before timer expiry so
    // an abort on the final OFF cycle never produces a missed pulse.
    assign w_abort  = answer || !call_in;
    assign w_tmr_en = (r_state == C_ST_RING_ON) || (r_state == C_ST_RING_OFF);

    cadence_timer #(
        .WIDTH    (C_TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_num_nxt    = r_ring_num;
        w_missed_nxt = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = C_ON_LOAD;

        case (r_state)
            C_ST_IDLE: begin
                if (call_in) begin
                    w_state_nxt = C_ST_RING_ON;
                    w_num_nxt   = C_NUM_ONE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_ON_LOAD;
                end
            end
            C_ST_RING_ON: begin
                if (w_abort) begin
                    w_state_nxt = C_ST_IDLE;
                    w_num_nxt   = '0;
                end else if (w_tmr_zero) begin
                    w_state_nxt = C_ST_RING_OFF;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = C_OFF_LOAD;
                end
            end
            C_ST_RING_OFF: begin
                if (w_abort) begin
                    w_state_nxt = C_ST_IDLE;
                    w_num_nxt   = '0;
                end else if (w_tmr_zero) begin
                    if (r_ring_num < C_MAX_NUM) begin
                        w_state_nxt = C_ST_RING_ON;
                        w_num_nxt   = r_ring_num + C_NUM_ONE;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = C_ON_LOAD;
                    end else begin
                        w_state_nxt  = C_ST_WAIT_CLEAR;
                        w_num_nxt    = '0;
                        w_missed_nxt = 1'b1;
                    end
                end
            end
            C_ST_WAIT_CLEAR: begin
                // Unanswered call must not re-ring until the caller clears
                if (!call_in) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
                w_num_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= C_ST_IDLE;
            r_ring     <= 1'b0;
            r_ringing  <= 1'b0;
            r_ring_num <= '0;
            r_missed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ring     <= (w_state_nxt == C_ST_RING_ON);
            r_ringing  <= (w_state_nxt == C_ST_RING_ON) || (w_state_nxt == C_ST_RING_OFF);
            r_ring_num <= w_num_nxt;
            r_missed   <= w_missed_nxt;
        end
    end

    assign ring     = r_ring;
    assign ringing  = r_ringing;
    assign ring_num = r_ring_num;
    assign missed   = r_missed;

`ifdef RING_MISSED_COUNT_EN
    logic [CNT_W-1:0] r_missed_count;

    // Counts on the same edge that raises the missed pulse; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_missed_count <= '0;
        end else if (clr_missed) begin
            r_missed_count <= '0;
        end else if (w_missed_nxt && (r_missed_count != '1)) begin
            r_missed_count <= r_missed_count + CNT_W'(1);
        end
    end

    assign missed_count = r_missed_count;
`endif

endmodule : ring_cadence_gen

`default_nettype wire

// File: tb/tb_ring_cadence_gen.sv
// ============================================================================
// Module   : tb_ring_cadence_gen
// Purpose  : Self-checking bench for ring_cadence_gen. A call-level reference
//            model (elapsed time since the first ring rise) predicts every
//            output each cycle; directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_cadence_gen;

    localparam int ON   = 8;
    localparam int OFF  = 16;
    localparam int MAXR = 4;
    localparam int TCW  = 2;
    localparam int P    = ON + OFF;
    localparam int NW   = $clog2(MAXR + 1);

    logic          clk;
    logic          rst_n;
    logic          call_in;
    logic          answer;
    logic          ring;
    logic          ringing;
    logic [NW-1:0] ring_num;
    logic          missed;
    logic          clr_missed;
`ifdef RING_MISSED_COUNT_EN
    logic [TCW-1:0] missed_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 calling, 2 waiting for clear
    int m_mode = 0;
    int m_t    = 0;
    int m_missed = 0;
    int m_cnt  = 0;

    ring_cadence_gen #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .MAX_RINGS  (MAXR),
        .CNT_W      (TCW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_in      (call_in),
        .answer       (answer),
        .ring         (ring),
        .ringing      (ringing),
        .ring_num     (ring_num),
        .missed       (missed)
`ifdef RING_MISSED_COUNT_EN
        ,
        .clr_missed   (clr_missed),
        .missed_count (missed_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT samples, then compare.
    task automatic step();
        @(posedge clk);
        m_missed = 0;
        if (!rst_n) begin
            m_mode = 0;
            m_t    = 0;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                0: if (call_in) begin m_mode = 1; m_t = 0; end
                1: begin
                    if (answer || !call_in) begin
                        m_mode = 0;
                    end else begin
                        m_t++;
                        if (m_t == MAXR * P) begin
                            m_mode = 2;
                            m_missed = 1;
                        end
                    end
                end
                default: if (!call_in) m_mode = 0;
            endcase
            if (clr_missed) m_cnt = 0;
            else if (m_missed == 1 && m_cnt < (1 << TCW) - 1) m_cnt++;
        end
        #1;
        check_val("ring",     {31'd0, ring},    (m_mode == 1 && (m_t % P) < ON) ? 32'd1 : 32'd0);
        check_val("ringing",  {31'd0, ringing}, (m_mode == 1) ? 32'd1 : 32'd0);
        check_val("ring_num", 32'(ring_num),    (m_mode == 1) ? 32'(m_t / P + 1) : 32'd0);
        check_val("missed",   {31'd0, missed},  32'(m_missed));
`ifdef RING_MISSED_COUNT_EN
        check_val("missed_count", 32'(missed_count), 32'(m_cnt));
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int miss_seen;
        int miss_at;
        int hold;

        rst_n = 1'b0; call_in = 1'b1; answer = 1'b0; clr_missed = 1'b0;

        // Reset held with call present
        steps(3);
        rst_n = 1'b1;
        step();
        check_val("release_ring", {31'd0, ring}, 32'd1);

        // Full unanswered call: 4 bursts, then one missed pulse 96 cycles after first rise
        miss_seen = 0; miss_at = 0;
        for (int i = 1; i <= 96; i++) begin
            step();
            if (missed === 1'b1) begin miss_seen++; miss_at = i; end
        end
        check_val("t2_miss_count", 32'(miss_seen), 32'd1);
        check_val("t2_miss_at",    32'(miss_at),   32'(MAXR * P));
        steps(5);
        call_in = 1'b0; step(); step();

        // Answer on the 3rd cycle of burst 2
        call_in = 1'b1; step();
        steps(P + 2);
        answer = 1'b1; step();
        check_val("t3_ring_num", 32'(ring_num), 32'd0);
        answer = 1'b0; call_in = 1'b0; step();

        // Hang-up on the exact cycle the final OFF timer expires
        call_in = 1'b1; step();
        steps(MAXR * P - 1);
        call_in = 1'b0; step();
        check_val("t4_no_miss", {31'd0, missed}, 32'd0);
        step();

        // Reset in the middle of burst 3, restart with call still present
        call_in = 1'b1; step();
        steps(2 * P + 3);
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        check_val("t5_restart_num", 32'(ring_num), 32'd1);
        call_in = 1'b0; step(); step();

`ifdef RING_MISSED_COUNT_EN
        // Five missed calls saturate a 2-bit counter; then clear against a pulse
        for (int c = 0; c < 5; c++) begin
            call_in = 1'b1; step();
            steps(MAXR * P);
            call_in = 1'b0; step(); step();
        end
        check_val("t6_saturated", 32'(missed_count), 32'd3);
        call_in = 1'b1; step();
        steps(MAXR * P - 1);
        clr_missed = 1'b1; step();
        check_val("t6_clr_vs_miss", 32'(missed_count), 32'd0);
        clr_missed = 1'b0; call_in = 1'b0; step(); step();
`endif

        // Random traffic
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                call_in = ~call_in;
                hold = call_in ? $urandom_range(1, 130) : $urandom_range(1, 6);
            end
            hold--;
            answer     = ($urandom % 60) == 0;
            rst_n      = ($urandom % 500) != 0;
            clr_missed = ($urandom % 40) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ring_cadence_gen

`default_nettype wire

// File: doc/ring_cadence_gen.md
Name: ring_cadence_gen

Overview:
- Upstream stage of ringer_module. Turns a level "incoming call present" request into the cadenced `ring` signal that ringer_module consumes.
- `vibrate_mode` passes straight through to ringer_module and is not handled here.
- Produces a fixed on/off ring cadence for a bounded number of rings.
- Stops on answer or caller hang-up; flags a missed call when the ring count runs out.

Parameters:
- ON_CYCLES, 8: clock cycles `ring` is high per ring burst (>=1).
- OFF_CYCLES, 16: clock cycles `ring` is low between bursts (>=1).
- MAX_RINGS, 4: bursts before the call is declared missed (>=1).
- CNT_W, 8: width of the missed-call counter (optional feature only).

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- call_in  in  1  level; high while a call is incoming.
- answer  in  1  user answered; sampled every cycle.
- ring  out  1  cadenced ring request to ringer_module; registered.
- ringing  out  1  high while in RING_ON or RING_OFF.
- ring_num  out  $clog2(MAX_RINGS+1)  current burst number (1..MAX_RINGS); 0 otherwise.
- missed  out  1  one-cycle pulse when the call is missed.

Behaviour:
- Reset: when rst_n=0 at a clk edge, state=IDLE and ring, ringing, ring_num, missed, timer all go to 0. Reset overrides all inputs, mid-call included.
- States: IDLE, RING_ON, RING_OFF, WAIT_CLEAR. All outputs are registered and decoded from the next state.
- IDLE:
  - call_in=1 -> RING_ON, timer=ON_CYCLES-1, ring_num=1.
  - Latency: ring is high in the cycle after call_in is first sampled high.
  - answer is ignored in IDLE.
- RING_ON (ring=1):
  - timer decrements each cycle.
  - At timer==0 -> RING_OFF, timer=OFF_CYCLES-1.
  - ring stays high exactly ON_CYCLES cycles.
- RING_OFF (ring=0):
  - timer decrements each cycle.
  - At timer==0 and ring_num<MAX_RINGS -> RING_ON, ring_num+1, timer=ON_CYCLES-1.
  - At timer==0 and ring_num==MAX_RINGS -> WAIT_CLEAR, missed=1 for exactly that cycle, ring_num=0.
- Abort: in RING_ON or RING_OFF, answer=1 or call_in=0 -> IDLE next cycle (ring=0, ring_num=0, no missed).
- Priority: abort beats timer expiry, so a simultaneous last-OFF expiry and abort gives no missed pulse. answer and call_in drop together are a plain abort.
- WAIT_CLEAR (ring=0, ringing=0):
  - Holds until call_in=0, then -> IDLE.
  - Prevents an unanswered call from re-ringing.
  - answer is ignored here.
- call_in re-asserting in the same cycle the machine enters IDLE is sampled next cycle (one-cycle gap minimum).
- Timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)), minimum 1 bit. The timer never wraps because it is reloaded on every transition.

Optional Feature:
- Macro: RING_MISSED_COUNT_EN.
- Defined:
  - Adds input clr_missed (1 bit) and output missed_count (CNT_W bits, reset 0).
  - missed_count increments on each missed pulse and saturates at 2^CNT_W-1.
  - clr_missed=1 clears the count to 0 and beats a simultaneous increment.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ring_pkg holds:
  - the state enum (IDLE=2'd0, RING_ON=2'd1, RING_OFF=2'd2, WAIT_CLEAR=2'd3);
  - the default cadence constants.
- Sub-module cadence_timer: loadable down-counter with load, load_val and zero-flag outputs. Instanced once and shared by the ON and OFF phases.

Test Plan (defaults ON=8, OFF=16, MAX=4 unless noted):
1. rst_n=0 for 3 cycles with call_in=1 -> ring=ringing=missed=0 and ring_num=0 throughout. Release rst_n -> ring=1 from the 2nd cycle after release.
2. call_in held high, answer=0 -> 4 bursts of 8 high / 16 low; ring_num steps 1..4; missed pulses once, 96 cycles after the first ring rise. ring stays 0 while call_in is held; dropping call_in -> IDLE next cycle.
3. answer=1 at the 3rd cycle of burst 2 -> ring=0 and ring_num=0 on the next cycle; missed never asserts.
4. call_in=0 on the exact cycle the 4th OFF timer reaches 0 -> IDLE, no missed pulse.
5. rst_n=0 mid-RING_ON of burst 3 -> all outputs 0 after that edge. Releasing with call_in still high restarts at ring_num=1.
6. RING_MISSED_COUNT_EN with CNT_W=2: 5 missed calls -> missed_count=3 (saturated). clr_missed=1 coinciding with a missed pulse -> missed_count=0.
